// File: rtl/host_seq_pkg.sv
// host_seq_pkg -- shared widths and state encoding for the host sequencer.
//   `H_C_W  : default width of the latched host controller word
//   `EX_bus : default width of the execution bus
//   seq_state_e : IDLE / INIT / RUN / DONE, binary encoded
`ifndef H_C_W
`define H_C_W 8
`endif
`ifndef EX_bus
`define EX_bus 8
`endif

package host_seq_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/seq_cnt.sv
// seq_cnt -- loadable down-counter with a "last cycle" flag.
//   clk, rst  : clock, async active-high reset (count -> 0)
//   load      : load load_val (wins over dec)
//   load_val  : value to load
//   dec       : decrement by one (saturates at zero)
//   last      : count == 1
module seq_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign last = (count == CNT_W'(1));
endmodule

// File: rtl/host_seq.sv
// host_seq -- command sequencer: on start, runs an INIT phase of
// init_cycles_i cycles, then a RUN phase of run_cycles_i cycles, then a
// one-cycle DONE pulse. Captures the host word at start and samples the
// execution bus during RUN.
//   clk, rst            : clock, async active-high reset
//   start_i             : start strobe (only honoured in IDLE)
//   abort_i             : cancel sequence, back to IDLE next edge
//   init_cycles_i       : INIT phase length
//   run_cycles_i        : RUN phase length (latched at start)
//   host_cfg_i          : host word, latched at start
//   ex_bus_i/ex_valid_i : execution bus, captured in RUN when valid
//   init_o / run_o      : phase indicators
//   host_controller_o   : latched host word
//   ex_bus_o            : captured execution bus value
//   busy_o / done_o     : not-idle flag / completion pulse
module host_seq
    import host_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int H_C_W = `H_C_W,
    parameter int EX_W  = `EX_bus
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] init_cycles_i,
    input  logic [CNT_W-1:0] run_cycles_i,
    input  logic [H_C_W-1:0] host_cfg_i,
    input  logic [EX_W-1:0]  ex_bus_i,
    input  logic             ex_valid_i,
    output logic             init_o,
    output logic             run_o,
    output logic [H_C_W-1:0] host_controller_o,
    output logic [EX_W-1:0]  ex_bus_o,
    output logic             busy_o,
    output logic             done_o
);
    seq_state_e       state, state_nxt;
    logic [CNT_W-1:0] run_lat;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_load, cnt_dec, cnt_last;
    logic             accept;

    // abort beats a simultaneous start in IDLE
    assign accept = (state == ST_IDLE) && start_i && !abort_i;

    seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = init_cycles_i;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    if (init_cycles_i != '0) begin
                        state_nxt    = ST_INIT;
                        cnt_load_val = init_cycles_i;
                    end else if (run_cycles_i != '0) begin
                        state_nxt    = ST_RUN;
                        cnt_load_val = run_cycles_i;
                    end else begin
                        state_nxt    = ST_DONE;
                    end
                end
            end
            ST_INIT: begin
                if (abort_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_last) begin
                    // hand straight over to RUN so there is no gap cycle
                    cnt_load_val = run_lat;
                    cnt_load     = 1'b1;
                    state_nxt    = (run_lat != '0) ? ST_RUN : ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort_i)       state_nxt = ST_IDLE;
                else if (cnt_last) state_nxt = ST_DONE;
                else               cnt_dec   = 1'b1;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state register without any input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_lat           <= '0;
            host_controller_o <= '0;
            ex_bus_o          <= '0;
            init_o            <= 1'b0;
            run_o             <= 1'b0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
        end else begin
            if (accept) begin
                run_lat           <= run_cycles_i;
                host_controller_o <= host_cfg_i;
                ex_bus_o          <= '0;
            end else if (state == ST_RUN && ex_valid_i && !abort_i) begin
                ex_bus_o <= ex_bus_i;
            end
            init_o <= (state_nxt == ST_INIT);
            run_o  <= (state_nxt == ST_RUN);
            busy_o <= (state_nxt != ST_IDLE);
            done_o <= (state_nxt == ST_DONE);
        end
    end
endmodule

// File: tb/tb_host_seq.sv
module tb_host_seq;
    localparam int CW = 12;
    localparam int HW = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, ex_valid = 1'b0;
    logic [CW-1:0] init_c = '0, run_c = '0;
    logic [HW-1:0] cfg = '0;
    logic [EW-1:0] bus = '0;
    logic          init_o, run_o, busy_o, done_o;
    logic [HW-1:0] host_o;
    logic [EW-1:0] ex_o;

    int checks = 0;
    int errors = 0;

    host_seq #(.CNT_W(CW), .H_C_W(HW), .EX_W(EW)) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .init_cycles_i(init_c), .run_cycles_i(run_c), .host_cfg_i(cfg),
        .ex_bus_i(bus), .ex_valid_i(ex_valid),
        .init_o(init_o), .run_o(run_o), .host_controller_o(host_o),
        .ex_bus_o(ex_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " outs"}, {28'd0, init_o, run_o, busy_o, done_o}, 32'd0);
        chk({name, " host"}, 32'(host_o), 32'd0);
        chk({name, " ex"}, 32'(ex_o), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    // ---------------- reference model ----------------
    // Phase codes: 0 idle, 1 init, 2 run, 3 done. A sequence is a list of
    // phases built from the counts at start; each edge consumes one entry.
    int            m_q[$];
    int            m_cur;
    logic [HW-1:0] m_host;
    logic [EW-1:0] m_ex;

    task automatic model_reset();
        m_q.delete();
        m_cur = 0; m_host = '0; m_ex = '0;
    endtask

    task automatic model_edge(input logic s, input logic a, input int ni, input int nr,
                              input logic [HW-1:0] c, input logic v, input logic [EW-1:0] b);
        if (m_cur != 0 && a) begin
            m_q.delete();
            m_cur = 0;
        end else if (m_cur == 0) begin
            if (s && !a) begin
                m_host = c;
                m_ex   = '0;
                for (int i = 0; i < ni; i++) m_q.push_back(1);
                for (int i = 0; i < nr; i++) m_q.push_back(2);
                m_q.push_back(3);
                m_cur = m_q.pop_front();
            end
        end else begin
            if (m_cur == 2 && v) m_ex = b;
            m_cur = (m_q.size() > 0) ? m_q.pop_front() : 0;
        end
    endtask

    typedef struct {
        int unsigned   ini;
        int unsigned   run;
        int unsigned   exp_done_cyc;
        logic [HW-1:0] cfg;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{3, 4, 8, 8'h11};
        vecs[1] = '{0, 2, 3, 8'h22};
        vecs[2] = '{0, 0, 1, 8'h33};
        vecs[3] = '{1, 0, 2, 8'h44};
        vecs[4] = '{2, 5, 8, 8'h55};
        vecs[5] = '{1, 1, 3, 8'h66};

        // reset state
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        step();
        chk_all_zero("post-reset idle");

        // table-driven sequences: per-cycle phase pattern
        foreach (vecs[k]) begin
            int unsigned ni, nr, dc;
            ni = vecs[k].ini; nr = vecs[k].run; dc = vecs[k].exp_done_cyc;
            init_c = CW'(ni); run_c = CW'(nr); cfg = vecs[k].cfg; start = 1'b1;
            step();
            start = 1'b0;
            for (int unsigned c = 1; c <= dc + 1; c++) begin
                logic [3:0] e;
                e = {c <= ni, c > ni && c <= ni + nr, c == dc, c <= dc};
                chk($sformatf("vec%0d cyc%0d {init,run,done,busy}", k, c),
                    {28'd0, init_o, run_o, done_o, busy_o}, {28'd0, e});
                if (c == 1) chk($sformatf("vec%0d host", k), 32'(host_o), 32'(vecs[k].cfg));
                step();
            end
        end

        // abort in 2nd RUN cycle of init=2 run=5
        init_c = 2; run_c = 5; cfg = 8'hC3; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("abort pre run_o", {31'd0, run_o}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy", {31'd0, busy_o}, 32'd0);
        chk("abort run", {31'd0, run_o}, 32'd0);
        chk("abort host", 32'(host_o), 32'hC3);
        for (int i = 0; i < 6; i++) begin
            chk("abort no done", {31'd0, done_o | busy_o}, 32'd0);
            step();
        end

        // ex bus capture: only in RUN, held after done
        init_c = 2; run_c = 2; cfg = 8'h0F; start = 1'b1;
        step();
        start = 1'b0;
        ex_valid = 1'b1; bus = 8'h3C;
        step();
        ex_valid = 1'b0;
        step();
        chk("ex in init ignored", 32'(ex_o), 32'd0);
        ex_valid = 1'b1; bus = 8'hA5;
        step();
        ex_valid = 1'b0; bus = 8'hFF;
        chk("ex captured", 32'(ex_o), 32'hA5);
        step();
        chk("ex done pulse", {31'd0, done_o}, 32'd1);
        step();
        ex_valid = 1'b1; bus = 8'h11;
        step();
        ex_valid = 1'b0;
        chk("ex held idle", 32'(ex_o), 32'hA5);

        // second start while busy ignored, count changes ignored
        init_c = 3; run_c = 1; cfg = 8'h5A; start = 1'b1;
        step();
        cfg = 8'h99; init_c = 0; run_c = 7;
        step();
        start = 1'b0;
        chk("busy start host", 32'(host_o), 32'h5A);
        step();
        chk("busy start init", {31'd0, init_o}, 32'd1);
        step();
        chk("busy start run", {30'd0, init_o, run_o}, 32'd1);
        step();
        chk("busy start done", {31'd0, done_o}, 32'd1);
        step();

        // reset mid-RUN: immediate clear, no done
        init_c = 1; run_c = 5; cfg = 8'hEE; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("pre-reset run", {31'd0, run_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post reset quiet", {28'd0, init_o, run_o, busy_o, done_o}, 32'd0);
        end

        // full-width count: 2^CW-1 init cycles without wrap
        begin
            int ni, nr, guard;
            bit got_done;
            ni = 0; nr = 0; guard = 0; got_done = 0;
            init_c = '1; run_c = 1; cfg = 8'h01; start = 1'b1;
            step();
            start = 1'b0;
            while (!got_done && guard < 5000) begin
                ni += int'(init_o);
                nr += int'(run_o);
                got_done = done_o;
                guard++;
                step();
            end
            chk("max init len", 32'(ni), 32'((1 << CW) - 1));
            chk("max run len", 32'(nr), 32'd1);
            chk("max done seen", {31'd0, got_done}, 32'd1);
        end

        // randomized run against the phase-list model
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            logic s, a, v;
            int ni, nr;
            logic [HW-1:0] c;
            logic [EW-1:0] b;
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 15) == 0);
            v  = $urandom_range(0, 1);
            ni = $urandom_range(0, 4);
            nr = $urandom_range(0, 4);
            c  = HW'($urandom);
            b  = EW'($urandom);
            start = s; abort = a; ex_valid = v; init_c = CW'(ni); run_c = CW'(nr);
            cfg = c; bus = b;
            step();
            model_edge(s, a, ni, nr, c, v, b);
            chk("rnd init", {31'd0, init_o}, {31'd0, m_cur == 1});
            chk("rnd run",  {31'd0, run_o},  {31'd0, m_cur == 2});
            chk("rnd done", {31'd0, done_o}, {31'd0, m_cur == 3});
            chk("rnd busy", {31'd0, busy_o}, {31'd0, m_cur != 0});
            chk("rnd host", 32'(host_o), 32'(m_host));
            chk("rnd ex",   32'(ex_o),   32'(m_ex));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
